// File: rtl/semaforo_cruce_param_if.sv
// semaforo_cruce_param_if
// Board-side signal bundle for the two-approach traffic-light controller.
//   on_off    : 1 = normal cycling, 0 = flashing amber (synchronous level)
//   luz_a     : street A lamps {rojo,amarillo,verde}, 1 = lit
//   luz_b     : street B lamps {rojo,amarillo,verde}, 1 = lit
//   estado    : current state code (debug/LEDs)
//   ped_req   : pedestrian button (only with SEMAFORO_PEATON_EN)
//   ped_verde : pedestrian walk lamp (only with SEMAFORO_PEATON_EN)
// Optional feature macro: SEMAFORO_PEATON_EN.
// Handshake: there is no valid/ready pair here; every signal is a plain level
// sampled or updated on the rising clock edge, inputs are assumed already
// synchronised to clk.
// Modports: master = the controller (drives lamps), slave = board/environment.
interface semaforo_cruce_param_if;
  logic       on_off;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic [3:0] estado;
`ifdef SEMAFORO_PEATON_EN
  logic       ped_req;
  logic       ped_verde;

  modport master (input on_off, input ped_req,
                  output luz_a, output luz_b, output estado, output ped_verde);
  modport slave  (output on_off, output ped_req,
                  input luz_a, input luz_b, input estado, input ped_verde);
`else
  modport master (input on_off, output luz_a, output luz_b, output estado);
  modport slave  (output on_off, input luz_a, input luz_b, input estado);
`endif
endinterface

// File: rtl/semaforo_cruce_param.sv
// semaforo_cruce_param
// Two-approach (street A / street B) traffic-light controller with an on-chip
// tick prescaler, lamp test after reset and flashing amber while switched off.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : semaforo_cruce_param_if.master (on_off, luz_a, luz_b, estado,
//           plus ped_req/ped_verde when SEMAFORO_PEATON_EN is defined)
// Optional feature macro: SEMAFORO_PEATON_EN (pedestrian request + walk phase).
// All lamp outputs are registered: they are decoded from the next state and
// loaded into flops together with the state register.
module semaforo_cruce_param #(
  parameter int CLK_DIV    = 50_000_000,
  parameter int PRE_W      = 26,
  parameter int T_VERDE    = 20,
  parameter int T_AMARILLO = 3,
  parameter int T_ROJO     = 1,
  parameter int T_TEST     = 2,
  parameter int T_BLINK    = 1,
  parameter int T_PEATON   = 10,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  semaforo_cruce_param_if.master bus
);

  typedef enum logic [3:0] {
    LAMP_TEST    = 4'd0,
    ROJO_B       = 4'd1,
    A_VERDE      = 4'd2,
    A_AMARILLO   = 4'd3,
    ROJO_A       = 4'd4,
    B_VERDE      = 4'd5,
    B_AMARILLO   = 4'd6,
    INTERMITENTE = 4'd7,
    PEATON       = 4'd8
  } state_t;

  state_t           state, state_next;
  logic [PRE_W-1:0] pre, pre_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic             blink, blink_next;
  logic [2:0]       luz_a, luz_a_next;
  logic [2:0]       luz_b, luz_b_next;
  logic             tick;
  logic             expire;
  logic             peaton_go;

  // Timer reload value (duration - 1) for a given state.
  function automatic logic [CNT_W-1:0] load_value(input state_t s);
    case (s)
      LAMP_TEST:            return CNT_W'(T_TEST - 1);
      A_VERDE, B_VERDE:     return CNT_W'(T_VERDE - 1);
      A_AMARILLO,
      B_AMARILLO:           return CNT_W'(T_AMARILLO - 1);
      INTERMITENTE:         return CNT_W'(T_BLINK - 1);
      PEATON:               return CNT_W'(T_PEATON - 1);
      default:              return CNT_W'(T_ROJO - 1);
    endcase
  endfunction

  // Lamp decode {luz_a, luz_b}; each lamp group is {rojo,amarillo,verde}.
  function automatic logic [5:0] lamps(input state_t s, input logic lit);
    case (s)
      LAMP_TEST:    return {3'b111, 3'b111};
      A_VERDE:      return {3'b001, 3'b100};
      A_AMARILLO:   return {3'b010, 3'b100};
      B_VERDE:      return {3'b100, 3'b001};
      B_AMARILLO:   return {3'b100, 3'b010};
      INTERMITENTE: return lit ? {3'b010, 3'b010} : 6'b000_000;
      default:      return {3'b100, 3'b100};
    endcase
  endfunction

  assign tick   = (pre == PRE_W'(CLK_DIV - 1));
  assign expire = tick && (timer == '0);

`ifdef SEMAFORO_PEATON_EN
  logic ped_latch, ped_latch_next;
  logic ped_verde, ped_verde_next;

  assign peaton_go = ped_latch && bus.on_off;

  // Sticky request; ignored while walking or flashing, cleared on PEATON entry.
  always_comb begin
    ped_latch_next = ped_latch;
    if (bus.ped_req && state != PEATON && state != INTERMITENTE)
      ped_latch_next = 1'b1;
    if (state_next == PEATON && state != PEATON)
      ped_latch_next = 1'b0;
    ped_verde_next = (state_next == PEATON);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_latch <= 1'b0;
      ped_verde <= 1'b0;
    end else begin
      ped_latch <= ped_latch_next;
      ped_verde <= ped_verde_next;
    end
  end

  assign bus.ped_verde = ped_verde;
`else
  assign peaton_go = 1'b0;
`endif

  always_comb begin
    state_next = state;
    timer_next = timer;
    blink_next = blink;
    pre_next   = tick ? '0 : pre + PRE_W'(1);

    unique case (state)
      LAMP_TEST:  if (expire) state_next = bus.on_off ? ROJO_B : INTERMITENTE;
      ROJO_B:     if (expire) state_next = bus.on_off ? A_VERDE : INTERMITENTE;
      // Switching off cuts green short immediately; amber still runs in full.
      A_VERDE:    if (!bus.on_off || expire) state_next = A_AMARILLO;
      A_AMARILLO: if (expire) state_next = !bus.on_off ? INTERMITENTE :
                                           (peaton_go ? PEATON : ROJO_A);
      ROJO_A:     if (expire) state_next = bus.on_off ? B_VERDE : INTERMITENTE;
      B_VERDE:    if (!bus.on_off || expire) state_next = B_AMARILLO;
      B_AMARILLO: if (expire) state_next = bus.on_off ? ROJO_B : INTERMITENTE;
      PEATON:     if (expire) state_next = bus.on_off ? ROJO_A : INTERMITENTE;
      // Leaving flash always goes through all-red before any green.
      INTERMITENTE: begin
        if (bus.on_off)  state_next = ROJO_B;
        else if (expire) blink_next = !blink;
      end
      default:    state_next = LAMP_TEST;
    endcase

    // Prescaler restart on every state change keeps each state exactly
    // T*CLK_DIV cycles long; flashing phase always starts lit.
    if (state_next != state) begin
      pre_next   = '0;
      timer_next = load_value(state_next);
      blink_next = 1'b1;
    end else if (tick) begin
      timer_next = (timer == '0) ? load_value(state) : timer - CNT_W'(1);
    end

    {luz_a_next, luz_b_next} = lamps(state_next, blink_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LAMP_TEST;
      pre   <= '0;
      timer <= CNT_W'(T_TEST - 1);
      blink <= 1'b1;
      luz_a <= 3'b111;
      luz_b <= 3'b111;
    end else begin
      state <= state_next;
      pre   <= pre_next;
      timer <= timer_next;
      blink <= blink_next;
      luz_a <= luz_a_next;
      luz_b <= luz_b_next;
    end
  end

  assign bus.luz_a  = luz_a;
  assign bus.luz_b  = luz_b;
  assign bus.estado = state;

endmodule
